// File: rtl/i2s_tx.sv
// I2S / left-justified serializer: one 16-bit sample per 32-slot frame, sent on both channels.
// Define I2S_TX_LJ_EN for left-justified framing; the default is standard Philips I2S.
module i2s_tx #(
  parameter int BCLK_DIV  = 4,
  parameter bit SIGNED_IN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [15:0] data,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        sample_strobe
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  logic [7:0]  div;
  logic [4:0]  s;
  logic [15:0] shadow;
  logic        run;
  logic [15:0] conv;
  logic [4:0]  s_nxt;

  assign conv  = SIGNED_IN ? data : {~data[15], data[14:0]};
  assign s_nxt = s + 5'd1;

  // Word select for a given slot; I2S leads the MSB by one bit clock.
  function automatic logic word_sel(input logic [4:0] slot);
    logic [4:0] ahead;
    ahead = slot + 5'd1;
`ifdef I2S_TX_LJ_EN
    word_sel = slot[4];
`else
    word_sel = ahead[4];
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div           <= '0;
      s             <= '0;
      shadow        <= '0;
      run           <= 1'b0;
      bclk          <= 1'b0;
      lrclk         <= 1'b0;
      sdata         <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      if (!ena) begin
        run   <= 1'b0;
        div   <= '0;
        s     <= '0;
        bclk  <= 1'b0;
        lrclk <= 1'b0;
        sdata <= 1'b0;
      end else if (!run) begin
        run           <= 1'b1;
        div           <= '0;
        s             <= '0;
        bclk          <= 1'b0;
        shadow        <= conv;
        sdata         <= conv[15];
        lrclk         <= word_sel(5'd0);
        sample_strobe <= 1'b1;
      end else if (div == DIV_LAST) begin
        div  <= '0;
        bclk <= ~bclk;
        // Falling bclk: advance slot and present its data/word select.
        if (bclk) begin
          s     <= s_nxt;
          lrclk <= word_sel(s_nxt);
          if (s_nxt == 5'd0) begin
            shadow        <= conv;
            sdata         <= conv[15];
            sample_strobe <= 1'b1;
          end else begin
            sdata <= shadow[~s_nxt[3:0]];
          end
        end
      end else begin
        div <= div + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: DAC-side decoder on rising bclk, scoreboard of expected words.
// Two instances (signed and offset-binary input) share the stimulus.
module tb_i2s_tx;

  localparam int DIV   = 2;
  localparam int FRAME = 64 * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [15:0] data;
  logic [1:0]  bclk_w, lrclk_w, sdata_w, strobe_w;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  bit          abort_req = 1'b0;
  bit          in_frame[2];
  bit          have_prev[2];
  bit          have_rise[2];
  bit          prev_bclk[2];
  int          k[2];
  int          last_strobe[2];
  int          last_rise[2];
  int          strobes[2];
  logic [15:0] word[2];
  logic [15:0] exp_w;
  bit          got;
  bit          exp_lr;

  i2s_tx #(.BCLK_DIV(DIV), .SIGNED_IN(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data(data),
    .bclk(bclk_w[0]), .lrclk(lrclk_w[0]), .sdata(sdata_w[0]), .sample_strobe(strobe_w[0])
  );

  i2s_tx #(.BCLK_DIV(DIV), .SIGNED_IN(1'b0)) u_off (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data(data),
    .bclk(bclk_w[1]), .lrclk(lrclk_w[1]), .sdata(sdata_w[1]), .sample_strobe(strobe_w[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    q0.push_back(d);
    q0.push_back(d);
    q1.push_back(d ^ 16'h8000);
    q1.push_back(d ^ 16'h8000);
    $display("push data=%h exp_sgn=%h exp_off=%h", d, d, d ^ 16'h8000);
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // DAC-side model: frame alignment from sample_strobe, bits sampled on rising bclk.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (abort_req) begin
        in_frame[i]  = 1'b0;
        have_prev[i] = 1'b0;
      end
      if (strobe_w[i]) begin
        strobes[i]++;
        if (have_prev[i]) chk("strobe_spacing", i, cyc - last_strobe[i], FRAME);
        have_prev[i]   = 1'b1;
        last_strobe[i] = cyc;
        in_frame[i]    = 1'b1;
        have_rise[i]   = 1'b0;
        k[i]           = 0;
      end
      if (in_frame[i] && bclk_w[i] && !prev_bclk[i]) begin
        if (have_rise[i]) chk("bclk_period", i, cyc - last_rise[i], 2 * DIV);
        have_rise[i] = 1'b1;
        last_rise[i] = cyc;
`ifdef I2S_TX_LJ_EN
        exp_lr = (k[i] >= 16);
`else
        exp_lr = (((k[i] + 1) % 32) >= 16);
`endif
        chk("lrclk_slot", i, lrclk_w[i], exp_lr);
        word[i][4'(15 - (k[i] % 16))] = sdata_w[i];
        if (k[i] % 16 == 15) begin
          got = 1'b0;
          if (i == 0 && q0.size() > 0) begin exp_w = q0.pop_front(); got = 1'b1; end
          if (i == 1 && q1.size() > 0) begin exp_w = q1.pop_front(); got = 1'b1; end
          chk("word_expected", i, got, 1);
          if (got) begin
            chk(k[i] < 16 ? "left_word" : "right_word", i, word[i], exp_w);
            $display("dut%0d %s word=%h exp=%h", i, k[i] < 16 ? "L" : "R", word[i], exp_w);
          end
        end
        k[i]++;
        if (k[i] == 32) in_frame[i] = 1'b0;
      end
      prev_bclk[i] = bclk_w[i];
    end
  end

  initial begin
    int cap0, cap5, cap_a;
    int sc[2];
    logic [15:0] frames[5];
    frames[0] = 16'hA5C3;
    frames[1] = 16'h8000;
    frames[2] = 16'h0000;
    frames[3] = 16'h1234;
    frames[4] = 16'hFFFF;

    rst_n = 1'b0;
    ena   = 1'b1;
    data  = frames[0];
    push(frames[0]);
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        chk("reset_outputs", i, {bclk_w[i], lrclk_w[i], sdata_w[i], strobe_w[i]}, 4'b0000);
    end

    rst_n = 1'b1;
    cap0  = cyc + 1;
    to_cycle(cap0 + 20);
    for (int i = 0; i < 2; i++) chk("single_start_strobe", i, strobes[i], 1);

    for (int f = 1; f < 5; f++) begin
      to_cycle(cap0 + FRAME * f - 64);
      data = frames[f];
      push(frames[f]);
    end

    cap5 = cap0 + FRAME * 5;
    to_cycle(cap5 + 42);
    for (int i = 0; i < 2; i++) chk("strobes_before_abort", i, strobes[i], 6);
    ena       = 1'b0;
    abort_req = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("abort_outputs", i, {bclk_w[i], lrclk_w[i], sdata_w[i], strobe_w[i]}, 4'b0000);
      sc[i] = strobes[i];
    end
    $display("abort at cycle %0d", cyc);

    to_cycle(cap5 + 60);
    for (int i = 0; i < 2; i++) begin
      chk("idle_no_strobe", i, strobes[i], sc[i]);
      chk("idle_bclk", i, bclk_w[i], 1'b0);
    end
    abort_req = 1'b0;
    data      = 16'h5A5A;
    push(16'h5A5A);
    ena   = 1'b1;
    cap_a = cyc + 1;
    to_cycle(cap_a);
    for (int i = 0; i < 2; i++) begin
      chk("restart_strobe", i, strobe_w[i], 1'b1);
      chk("restart_msb", i, sdata_w[i], (i == 0) ? 1'b0 : 1'b1);
    end

    to_cycle(cap_a + FRAME + 4);
    chk("queue_drained", 0, q0.size(), 0);
    chk("queue_drained", 1, q1.size(), 0);
    for (int i = 0; i < 2; i++) chk("total_strobes", i, strobes[i], sc[i] + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
